// File: rtl/vend_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vend_pkg                                                           |
// | Shared types, coin weights and width helper for the vending FSM.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package vend_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        VEND    = 2'd1,
        CHANGE  = 2'd2
    } vend_state_e;

    localparam int HALF_W = 1;
    localparam int ONE_W  = 2;

    // Credit can peak at price+2 (one half short, then both coins together)
    function automatic int calc_cw(input int price_halves);
        return $clog2(price_halves + 3);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vend_change_ctr.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vend_change_ctr                                                    |
// | Loadable down-counter holding owed change; done marks last pulse.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module vend_change_ctr
    import vend_pkg::*;
#(
    parameter int CW = 3
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    input  logic          dec_i,
    output logic [CW-1:0] count_o,
    output logic          zero_o,
    output logic          done_o
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);
    assign done_o  = (count_q == CW'(1));

endmodule
`default_nettype wire

// File: rtl/vend_fsm_param.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vend_fsm_param                                                     |
// | Two-coin vending FSM with programmable price and serial change.    |
// | Optional stock counter: define VEND_STOCK_EN.                      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module vend_fsm_param
    import vend_pkg::*;
#(
    parameter int PRICE_HALVES = 5,
    parameter int CW           = calc_cw(PRICE_HALVES),
    parameter int STOCK_INIT   = 8
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic          pay,
    input  logic          pay_half,
    input  logic          cancel,
    input  logic          restock,
    output logic          coin_ready,
    output logic          coke,
    output logic          ret,
    output logic [CW-1:0] credit,
    output logic          sold_out
);

    localparam logic [CW-1:0] PRICE_C = CW'(PRICE_HALVES);

    vend_state_e   state_q, state_d;
    logic [CW-1:0] credit_q, credit_d;
    logic [CW-1:0] coin_sum;
    logic          chg_ld, chg_dec;
    logic [CW-1:0] chg_ld_val;
    logic [CW-1:0] chg_count;
    logic          chg_zero, chg_done;
    logic          coke_q, ret_q, ready_q, sold_q;
    logic          stock_empty, sold_d;

`ifdef VEND_STOCK_EN
    localparam int   SW       = (STOCK_INIT < 1) ? 1 : $clog2(STOCK_INIT + 1);
    localparam logic RST_SOLD = (STOCK_INIT == 0);

    logic [SW-1:0] stock_q, stock_d;

    always_comb begin
        stock_d = stock_q;
        if ((state_q == VEND) && (stock_q != '0)) begin
            stock_d = stock_q - SW'(1);
        end else if ((state_q == COLLECT) && restock) begin
            stock_d = SW'(STOCK_INIT);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            stock_q <= SW'(STOCK_INIT);
        end else begin
            stock_q <= stock_d;
        end
    end

    assign stock_empty = (stock_q == '0);
    assign sold_d      = (stock_d == '0);
`else
    localparam logic RST_SOLD = 1'b0;

    logic w_unused_restock;
    assign w_unused_restock = restock ^ (STOCK_INIT != 0);
    assign stock_empty      = 1'b0;
    assign sold_d           = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        credit_d   = credit_q;
        chg_ld     = 1'b0;
        chg_ld_val = '0;
        chg_dec    = 1'b0;
        coin_sum   = credit_q + (pay ? CW'(ONE_W) : '0) + (pay_half ? CW'(HALF_W) : '0);
        unique case (state_q)
            COLLECT: begin
                // Sold out: coins are refused and any leftover balance is paid back
                if (stock_empty) begin
                    if (credit_q != '0) begin
                        state_d    = CHANGE;
                        chg_ld     = 1'b1;
                        chg_ld_val = credit_q;
                        credit_d   = '0;
                    end
                end else if (coin_sum >= PRICE_C) begin
                    state_d    = VEND;
                    chg_ld     = 1'b1;
                    chg_ld_val = coin_sum - PRICE_C;
                    credit_d   = '0;
                end else if (cancel && (coin_sum != '0)) begin
                    state_d    = CHANGE;
                    chg_ld     = 1'b1;
                    chg_ld_val = coin_sum;
                    credit_d   = '0;
                end else begin
                    credit_d = coin_sum;
                end
            end
            VEND: begin
                state_d = chg_zero ? COLLECT : CHANGE;
            end
            CHANGE: begin
                chg_dec = 1'b1;
                if (chg_done || chg_zero) begin
                    state_d = COLLECT;
                end
            end
            default: begin
                state_d  = COLLECT;
                credit_d = '0;
            end
        endcase
    end

    // Outputs are registered from the next-state decode so they align with state_q
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q  <= COLLECT;
            credit_q <= '0;
            coke_q   <= 1'b0;
            ret_q    <= 1'b0;
            ready_q  <= ~RST_SOLD;
            sold_q   <= RST_SOLD;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            coke_q   <= (state_d == VEND);
            ret_q    <= (state_d == CHANGE);
            ready_q  <= (state_d == COLLECT) && !sold_d;
            sold_q   <= sold_d;
        end
    end

    vend_change_ctr #(
        .CW (CW)
    ) u_change_ctr (
        .clk_i      (sys_clk),
        .rst_i      (sys_rst),
        .load_i     (chg_ld),
        .load_val_i (chg_ld_val),
        .dec_i      (chg_dec),
        .count_o    (chg_count),
        .zero_o     (chg_zero),
        .done_o     (chg_done)
    );

    assign coin_ready = ready_q;
    assign coke       = coke_q;
    assign ret        = ret_q;
    assign credit     = (state_q == CHANGE) ? chg_count : credit_q;
    assign sold_out   = sold_q;

endmodule
`default_nettype wire

// File: tb/tb_vend_fsm_param.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_vend_fsm_param                                                  |
// | Scoreboard bench for vend_fsm_param (PRICE_HALVES=5).              |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_vend_fsm_param;

    localparam int PRICE = 5;
    localparam int CW    = 3;
`ifdef VEND_STOCK_EN
    localparam int STOCK    = 1;
    localparam bit STOCK_EN = 1'b1;
`else
    localparam int STOCK    = 8;
    localparam bit STOCK_EN = 1'b0;
`endif

    logic          sys_clk = 1'b0;
    logic          sys_rst, pay, pay_half, cancel, restock;
    logic          coin_ready, coke, ret, sold_out;
    logic [CW-1:0] credit;

    vend_fsm_param #(
        .PRICE_HALVES (PRICE),
        .CW           (CW),
        .STOCK_INIT   (STOCK)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .pay        (pay),
        .pay_half   (pay_half),
        .cancel     (cancel),
        .restock    (restock),
        .coin_ready (coin_ready),
        .coke       (coke),
        .ret        (ret),
        .credit     (credit),
        .sold_out   (sold_out)
    );

    always #5 sys_clk = ~sys_clk;

    // {coin_ready, coke, ret, sold_out, credit}
    typedef logic [CW+3:0] obs_t;
    obs_t  exp_q[$];
    int    n_chk = 0;
    int    n_err = 0;
    int    n_ret, n_coke, n_busy;
    int    m_st, m_credit, m_change, m_stock;
    string scen = "init";

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour: m_st 0=collect, 1=vend, 2=change
    task automatic model_step(input logic p, input logic ph, input logic c,
                              input logic rs, input logic rk, output obs_t e);
        int sum;
        bit sold;
        if (rs) begin
            m_st = 0; m_credit = 0; m_change = 0; m_stock = STOCK;
        end else begin
            case (m_st)
                0: begin
                    sold = STOCK_EN && (m_stock == 0);
                    if (rk && STOCK_EN) m_stock = STOCK;
                    if (sold) begin
                        if (m_credit > 0) begin
                            m_change = m_credit; m_credit = 0; m_st = 2;
                        end
                    end else begin
                        sum = m_credit + (p ? 2 : 0) + (ph ? 1 : 0);
                        if (sum >= PRICE) begin
                            m_change = sum - PRICE; m_credit = 0; m_st = 1;
                        end else if (c && sum > 0) begin
                            m_change = sum; m_credit = 0; m_st = 2;
                        end else begin
                            m_credit = sum;
                        end
                    end
                end
                1: begin
                    if (STOCK_EN && m_stock > 0) m_stock--;
                    m_st = (m_change > 0) ? 2 : 0;
                end
                default: begin
                    m_change--;
                    if (m_change == 0) m_st = 0;
                end
            endcase
        end
        sold = STOCK_EN && (m_stock == 0);
        e = '0;
        e[CW+3]   = (m_st == 0) && !sold;
        e[CW+2]   = (m_st == 1);
        e[CW+1]   = (m_st == 2);
        e[CW]     = sold;
        e[CW-1:0] = CW'((m_st == 2) ? m_change : m_credit);
    endtask

    // Called at a falling edge: drive, predict, clock, compare
    task automatic cyc(input logic p, input logic ph, input logic c, input logic rs, input logic rk);
        obs_t e, got;
        pay = p; pay_half = ph; cancel = c; sys_rst = rs; restock = rk;
        model_step(p, ph, c, rs, rk, e);
        exp_q.push_back(e);
        @(posedge sys_clk);
        #1;
        got = {coin_ready, coke, ret, sold_out, credit};
        e   = exp_q.pop_front();
        check_eq(scen, got, e);
        if (ret === 1'b1)         n_ret++;
        if (coke === 1'b1)        n_coke++;
        if (coin_ready !== 1'b1)  n_busy++;
        @(negedge sys_clk);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic start(input string name);
        scen = name;
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        n_ret = 0; n_coke = 0; n_busy = 0;
    endtask

    initial begin
        sys_rst = 1'b1; pay = 1'b0; pay_half = 1'b0; cancel = 1'b0; restock = 1'b0;
        @(negedge sys_clk);

        start("reset");
        check_eq("rst_credit", credit, 0);
        check_eq("rst_ready", coin_ready, 1);
        check_eq("rst_coke", coke, 0);
        check_eq("rst_ret", ret, 0);

        start("exact_price");
        cyc(1, 0, 0, 0, 0);
        check_eq("exact_credit2", credit, 2);
        cyc(1, 0, 0, 0, 0);
        check_eq("exact_credit4", credit, 4);
        cyc(0, 1, 0, 0, 0);
        check_eq("exact_coke", coke, 1);
        idle(3);
        check_eq("exact_ncoke", n_coke, 1);
        check_eq("exact_nret", n_ret, 0);
        check_eq("exact_credit0", credit, 0);

        start("over_by_one");
        cyc(1, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0);
        idle(4);
        check_eq("over1_ncoke", n_coke, 1);
        check_eq("over1_nret", n_ret, 1);
        check_eq("over1_busy", n_busy, 2);

        start("both_coins");
        cyc(1, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0); cyc(1, 1, 0, 0, 0);
        idle(5);
        check_eq("both_ncoke", n_coke, 1);
        check_eq("both_nret", n_ret, 2);
        check_eq("both_busy", n_busy, 3);

        start("cancel");
        cyc(1, 0, 0, 0, 0); cyc(0, 0, 1, 0, 0);
        idle(4);
        check_eq("cancel_nret", n_ret, 2);
        check_eq("cancel_ncoke", n_coke, 0);
        check_eq("cancel_credit", credit, 0);
        n_ret = 0; n_busy = 0;
        cyc(0, 0, 1, 0, 0);
        idle(2);
        check_eq("cancel0_nret", n_ret, 0);
        check_eq("cancel0_busy", n_busy, 0);

        start("coin_in_change");
        cyc(1, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0); cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0);
        idle(2);
        check_eq("ignore_credit", credit, 0);
        check_eq("ignore_nret", n_ret, 2);

        start("reset_in_change");
        cyc(1, 0, 0, 0, 0); cyc(0, 0, 1, 0, 0);
        check_eq("rchg_ret_before", ret, 1);
        cyc(0, 0, 0, 1, 0);
        check_eq("rchg_ret", ret, 0);
        check_eq("rchg_credit", credit, 0);
        idle(2);

        start("random");
        repeat (400) begin
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 7) == 0, $urandom_range(0, 59) == 0,
                $urandom_range(0, 9) == 0);
        end

`ifdef VEND_STOCK_EN
        start("stock");
        cyc(1, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0);
        idle(3);
        check_eq("stock_sold", sold_out, 1);
        check_eq("stock_ready", coin_ready, 0);
        cyc(1, 0, 0, 0, 0);
        check_eq("stock_refused", credit, 0);
        cyc(0, 0, 0, 0, 1);
        check_eq("stock_restock", sold_out, 0);
        cyc(1, 0, 0, 0, 0);
        check_eq("stock_credit2", credit, 2);
        n_ret = 0;
        force dut.stock_q = '0;
        m_stock = 0;
        cyc(0, 0, 0, 0, 0);
        release dut.stock_q;
        idle(3);
        check_eq("stock_refund_nret", n_ret, 2);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vend_fsm_param.md
Name: vend_fsm_param

Overview:
Parametrised successor to the two-coin drink-vending FSM. Accepts half-unit and one-unit coins, credits them toward a programmable price, and vends one drink. It returns overpayment or a cancelled balance as serial half-unit change pulses. Sits behind the coin-acceptor front end, sharing sys_clk with the rest of the vending datapath.

Parameters:
PRICE_HALVES, 5, drink price in half-units (5 = 2.5); legal range 1..60
CW, $clog2(PRICE_HALVES+3), credit/change counter width; covers max credit PRICE_HALVES+2
STOCK_INIT, 8, drinks loaded at reset/restock (used only with VEND_STOCK_EN)

Ports:
sys_clk  in  1  system clock, all logic on rising edge
sys_rst  in  1  synchronous reset, active-high
pay  in  1  one-unit coin strobe (+2 halves), 1-cycle pulse
pay_half  in  1  half-unit coin strobe (+1 half), 1-cycle pulse
cancel  in  1  refund request, 1-cycle pulse
restock  in  1  reload stock counter (VEND_STOCK_EN only, else ignored)
coin_ready  out  1  high when coins/cancel are accepted (state COLLECT)
coke  out  1  registered 1-cycle vend pulse
ret  out  1  registered 1-cycle pulse per half-unit of change
credit  out  CW  current credit in half-units
sold_out  out  1  stock empty (tied 0 without VEND_STOCK_EN)

Behaviour:
- Reset (sampled on sys_clk when sys_rst=1): state=COLLECT, credit=0, coke=0, ret=0, change=0, coin_ready=1. Mid-operation reset discards pending vend/change.
- States: COLLECT, VEND, CHANGE (encoding from package).
- COLLECT: coin_ready=1. Each cycle, credit_next = credit + 2*pay + pay_half. pay and pay_half high together: both accepted (+3).
  - credit_next >= PRICE_HALVES -> VEND next cycle; change = credit_next - PRICE_HALVES.
  - Else if cancel && credit_next>0 -> CHANGE with change=credit_next. Coin plus cancel in the same cycle: the coin counts, then the full balance is refunded.
  - cancel with credit_next=0: ignored.
  - Price reached plus cancel in the same cycle: the vend wins and cancel is dropped.
- VEND: exactly one cycle.
  - coke=1, credit=0, coin_ready=0.
  - change>0 -> CHANGE, else -> COLLECT.
  - Latency: coke is high the cycle after the edge that sampled the final coin.
- CHANGE: coin_ready=0.
  - ret=1 each cycle, change decrements by 1 per cycle. Credit shows the remaining change.
  - The last pulse (change 1->0) returns to COLLECT. Exactly N ret pulses for N halves, back-to-back.
- Coin strobes and cancel while coin_ready=0 are ignored (not credited). The upstream acceptor must hold off.
- All outputs are registered; no combinational input->output paths.

Optional Feature:
VEND_STOCK_EN
- Defined: adds a stock counter, loaded with STOCK_INIT at reset.
  - Counter decrements on each coke pulse. sold_out = (stock==0).
  - While sold_out, coin_ready=0 in COLLECT. Any nonzero credit is refunded via CHANGE.
  - restock (in COLLECT) reloads STOCK_INIT.
- Undefined: no counter; sold_out=0; restock is ignored; behaviour is otherwise identical.

Decomposition:
- Package vend_pkg holds:
  - the state enum typedef (COLLECT/VEND/CHANGE)
  - coin weights HALF_W=1, ONE_W=2
  - helper function for the CW calculation
- Natural sub-module: vend_change_ctr, the loadable down-counter emitting ret pulses and a done flag. It is reused by the CHANGE state.

Test Plan:
- PRICE_HALVES=5; pay, pay, pay_half on consecutive cycles -> credit 2,4,5; coke=1 one cycle later; ret never pulses; back to COLLECT with credit=0.
- pay x3 -> credit 6; coke one cycle, then exactly 1 ret pulse; coin_ready low for 2 cycles.
- Credit 4, then pay+pay_half together -> credit 7; coke, then 2 back-to-back ret pulses.
- pay, then cancel -> 2 ret pulses, no coke, credit=0; cancel at credit 0 -> no activity.
- During CHANGE, drive pay -> not credited; after return to COLLECT, credit=0. Assert sys_rst mid-CHANGE -> ret=0 and credit=0 next cycle.
- VEND_STOCK_EN, STOCK_INIT=1:
  - vend once -> sold_out=1, coin_ready=0.
  - restock -> sold_out=0.
  - Also with credit 2, force stock to 0 -> 2 ret pulses.
